// File: rtl/reg_writeback_queue_pkg.sv
// Shared constants for the register write-back queue.
//   DEF_ADDR_W / DEF_DATA_W / DEF_DEPTH : default geometry
//   NUM_REGS                            : architectural register count
//   ZERO_REG                            : hard-wired zero register number
package reg_writeback_queue_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned DEF_ADDR_W = $clog2(NUM_REGS);
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 4;

  localparam logic [DEF_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_writeback_queue_if.sv
// Bundle of the decode, result-bus and register-file-write signals of the write-back queue.
//   master : the queue itself (drives stall/busy/ready, write port and count)
//   slave  : the environment (decode, producer) facing the queue
interface reg_writeback_queue_if
  import reg_writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              Issue_Valid;
  logic [ADDR_W-1:0] Issue_Reg_Num;
  logic              Issue_Stall;
  logic [ADDR_W-1:0] Src_Reg_Num_1;
  logic [ADDR_W-1:0] Src_Reg_Num_2;
  logic              Src_Busy_1;
  logic              Src_Busy_2;
  logic              Result_Valid;
  logic [ADDR_W-1:0] Result_Reg_Num;
  logic [DATA_W-1:0] Result_Data;
  logic              Result_Ready;
  logic [ADDR_W-1:0] Write_Reg_Num;
  logic [DATA_W-1:0] Write_Data;
  logic              RegWrite;
  logic [$clog2(DEPTH):0] Queue_Count;

  modport master (
    input  Issue_Valid, Issue_Reg_Num, Src_Reg_Num_1, Src_Reg_Num_2,
           Result_Valid, Result_Reg_Num, Result_Data,
    output Issue_Stall, Src_Busy_1, Src_Busy_2, Result_Ready,
           Write_Reg_Num, Write_Data, RegWrite, Queue_Count
  );

  modport slave (
    output Issue_Valid, Issue_Reg_Num, Src_Reg_Num_1, Src_Reg_Num_2,
           Result_Valid, Result_Reg_Num, Result_Data,
    input  Issue_Stall, Src_Busy_1, Src_Busy_2, Result_Ready,
           Write_Reg_Num, Write_Data, RegWrite, Queue_Count
  );

endinterface

// File: rtl/reg_writeback_queue_wb_fifo.sv
// Synchronous DEPTH-entry FIFO with registered occupancy count.
//   clk, rst_n   : clock, async active-low reset (empties the FIFO)
//   push_i/data  : write an entry (ignored when full)
//   pop_i        : drop the head (ignored when empty); pop_data_o is the current head
//   count_o      : entries held after the last edge
//   empty_o      : no entries held
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 37
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full;
  logic             push_eff;
  logic             pop_eff;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign push_eff = push_i && !full;
  assign pop_eff  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_eff)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/reg_writeback_queue.sv
// Register write-back queue: buffers execute/memory results and drives the register
// file write port at most once per clock, with a per-register pending scoreboard for
// decode RAW/WAW stalls.
//   clk, rst_n : clock, async active-low reset
//   bus        : decode issue/source lookups, result handshake, register file write
//                port (Write_Reg_Num, Write_Data, RegWrite) and Queue_Count
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_writeback_queue_if.master bus
);

  localparam int unsigned NumRegs = 1 << ADDR_W;
  localparam int unsigned CntW    = $clog2(DEPTH) + 1;
  localparam int unsigned EntryW  = ADDR_W + DATA_W;

  logic [EntryW-1:0] head;
  logic              fifo_empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic              commit_hit;
  logic              issue_set;

  logic [NumRegs-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0]  wr_num_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic               regwrite_q;

  // No pop pass-through: a full queue refuses even when it drains this edge.
  assign bus.Result_Ready = (bus.Queue_Count < CntW'(DEPTH));
  assign accept = bus.Result_Valid && bus.Result_Ready;
  // r0 results complete the handshake but are dropped.
  assign push   = accept && (bus.Result_Reg_Num != ADDR_W'(ZERO_REG));
  assign pop    = !fifo_empty;

  wb_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EntryW)
  ) u_wb_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i({bus.Result_Reg_Num, bus.Result_Data}),
    .pop_i      (pop),
    .pop_data_o (head),
    .count_o    (bus.Queue_Count),
    .empty_o    (fifo_empty)
  );

  // A register committing this edge may be re-issued in the same cycle.
  assign commit_hit      = regwrite_q && (wr_num_q == bus.Issue_Reg_Num);
  assign bus.Issue_Stall = pending_q[bus.Issue_Reg_Num] && !commit_hit;
  assign issue_set       = bus.Issue_Valid && !bus.Issue_Stall &&
                           (bus.Issue_Reg_Num != ADDR_W'(ZERO_REG));

  assign bus.Src_Busy_1 = pending_q[bus.Src_Reg_Num_1] &&
                          (bus.Src_Reg_Num_1 != ADDR_W'(ZERO_REG));
  assign bus.Src_Busy_2 = pending_q[bus.Src_Reg_Num_2] &&
                          (bus.Src_Reg_Num_2 != ADDR_W'(ZERO_REG));

  // Clear first, then set, so a coincident issue keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (regwrite_q) pending_d[wr_num_q] = 1'b0;
    if (issue_set)  pending_d[bus.Issue_Reg_Num] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      regwrite_q <= 1'b0;
      wr_num_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      pending_q  <= pending_d;
      regwrite_q <= pop;
      if (pop) begin
        wr_num_q  <= head[EntryW-1:DATA_W];
        wr_data_q <= head[DATA_W-1:0];
      end
    end
  end

  assign bus.RegWrite      = regwrite_q;
  assign bus.Write_Reg_Num = wr_num_q;
  assign bus.Write_Data    = wr_data_q;

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side initiator for the 32x32 register file: buffers completed results from execute/memory and drives the file's write port (Write_Reg_Num, Write_Data, RegWrite) at most once per clock.
- Holds a per-register pending scoreboard so decode can stall on RAW and WAW hazards until the value is committed.
- Sits between the execute/memory result bus and the register file write port.

Parameters:
- DEPTH, 4, result FIFO entries (power of two, >=2)
- DATA_W, 32, result data width
- ADDR_W, 5, register number width (32 registers)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- Issue_Valid  in  1  decode issues an instruction that writes Issue_Reg_Num
- Issue_Reg_Num  in  ADDR_W  destination register of the issued instruction
- Issue_Stall  out  1  destination is already pending; decode must hold the issue
- Src_Reg_Num_1  in  ADDR_W  decode source operand 1
- Src_Reg_Num_2  in  ADDR_W  decode source operand 2
- Src_Busy_1  out  1  source 1 has an uncommitted write
- Src_Busy_2  out  1  source 2 has an uncommitted write
- Result_Valid  in  1  producer offers a result
- Result_Reg_Num  in  ADDR_W  result destination
- Result_Data  in  DATA_W  result value
- Result_Ready  out  1  queue accepts a result this cycle
- Write_Reg_Num  out  ADDR_W  to register file
- Write_Data  out  DATA_W  to register file
- RegWrite  out  1  to register file
- Queue_Count  out  $clog2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (async assert, sync release): FIFO empty, all pending bits 0. RegWrite=0, Write_Reg_Num=0, Write_Data=0, Queue_Count=0. Register file contents are untouched. Reset mid-operation discards queued results and the in-flight write.
- Accept: a result is taken on the edge where Result_Valid && Result_Ready. Result_Ready = (Queue_Count < DEPTH), with no same-cycle pop pass-through. The producer holds Result_* stable while Valid && !Ready.
- Register 0: results with Result_Reg_Num==0 are accepted (handshake completes) but not enqueued. Issue to register 0 never sets a pending bit. Src_Busy_x is always 0 for register 0.
- Drain:
  - Each edge, if the FIFO is non-empty, pop the head into the output registers and set RegWrite=1 for the next cycle. If the FIFO is empty, RegWrite=0; Write_Reg_Num and Write_Data hold their last value.
  - Push and pop in the same edge are both performed, and the count is unchanged.
- Latency: a result accepted at edge N into an empty queue is popped at edge N+1, with RegWrite high during cycle N+1..N+2, and the register file commits at edge N+2. Throughput is 1 write per cycle.
- Scoreboard:
  - pending[r] is set on the edge where Issue_Valid && !Issue_Stall && r==Issue_Reg_Num && r!=0.
  - pending[r] is cleared on the edge where RegWrite && Write_Reg_Num==r. This is the same edge the register file writes, so a read after that edge returns the new value without bypass.
  - If set and clear hit the same register on the same edge, set wins.
- Combinational outputs:
  - Src_Busy_x = pending[Src_Reg_Num_x].
  - Issue_Stall = pending[Issue_Reg_Num] && !(RegWrite && Write_Reg_Num==Issue_Reg_Num). This permits back-to-back reuse of a register on its commit edge.
- A result for a register with no pending bit is still written. The clear is a no-op.
- FIFO order is strict arrival order. Results to the same register commit in arrival order.
- Queue_Count is registered and equals the number of FIFO entries after the edge.

Decomposition:
- Shared package: ADDR_W and DATA_W defaults, ZERO_REG constant (5'd0), NUM_REGS (32).
- One sub-module: wb_fifo, a synchronous DEPTH-entry FIFO with push/pop/count and async active-low reset. Scoreboard and output registers stay in the top.

Test Plan:
- Reset then idle -> RegWrite=0, Write_Reg_Num=0, Write_Data=0, Queue_Count=0, Result_Ready=1, all busy/stall outputs 0.
- Issue r5; result (r5, 0xDEADBEEF) at edge N -> Src_Busy for r5 =1 until edge N+2; RegWrite=1 with r5/0xDEADBEEF in cycle N+1; Src_Busy for r5 =0 after edge N+2.
- 5 results back-to-back with DEPTH=4 and no pops possible is not reachable, so hold Result_Valid for 6 cycles with 6 distinct regs -> Queue_Count never exceeds DEPTH; 6 RegWrite pulses in arrival order, one per cycle.
- Result to r0 (data 0x1234) -> handshake completes, Queue_Count stays 0, RegWrite never asserted; Issue r0 -> Issue_Stall=0, Src_Busy for r0 =0.
- r7 pending and committing (RegWrite, Write_Reg_Num=7) while Issue_Valid r7 -> Issue_Stall=0; pending[7]=1 after the edge (set wins).
- Assert rst_n=0 mid-burst with 3 queued entries -> RegWrite drops immediately; after release Queue_Count=0, no stale writes, all pending 0.
